// File: rtl/freq_meter_gated_if.sv
// Measurement bus of the gated frequency meter; FREQ_METER_BCD_EN adds the freq_bcd result.
interface freq_meter_gated_if #(
  parameter int CNT_W = 24
`ifdef FREQ_METER_BCD_EN
  , parameter int BCD_DIGITS = 8
`endif
);
  logic             en;
  logic             fx_in;
  logic [1:0]       gate_sel;
  logic [CNT_W-1:0] freq;
  logic             overflow;
  logic             valid;
  logic             busy;
`ifdef FREQ_METER_BCD_EN
  logic [4*BCD_DIGITS-1:0] freq_bcd;

  modport master (output en, fx_in, gate_sel, input freq, overflow, valid, busy, freq_bcd);
  modport slave  (input en, fx_in, gate_sel, output freq, overflow, valid, busy, freq_bcd);
`else
  modport master (output en, fx_in, gate_sel, input freq, overflow, valid, busy);
  modport slave  (input en, fx_in, gate_sel, output freq, overflow, valid, busy);
`endif
endinterface

// File: rtl/freq_meter_gated.sv
// Gated frequency meter: counts synchronised fx_in rising edges per clk-timed window; FREQ_METER_BCD_EN adds a BCD result.
// Result 1 clk after window close (CNT_W+1 with BCD); no backpressure, valid is a single-cycle pulse.
module freq_meter_gated #(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int BCD_DIGITS  = 8
) (
  input logic clk,
  input logic rst,
  freq_meter_gated_if.slave bus
);
  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (SYNC_STAGES < 2 || BCD_DIGITS < 1) begin : g_bad_params
    $error("freq_meter_gated: SYNC_STAGES must be >= 2 and BCD_DIGITS >= 1");
  end

  typedef enum logic {S_IDLE, S_GATE} state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic             ovf_q, ovf_d, ovf_nxt;
  logic             close;
  logic [SYNC_STAGES:0] sync_q;
  logic             fx_edge;
  logic [CNT_W-1:0] freq_q;
  logic             overflow_q;
  logic             valid_q;

  // Last gate_cnt value of a window; very short windows clamp to one cycle.
  function automatic logic [GW-1:0] win_last(input logic [1:0] sel);
    int w;
    case (sel)
      2'd0:    w = GATE_CYCLES;
      2'd1:    w = GATE_CYCLES / 10;
      2'd2:    w = GATE_CYCLES / 100;
      default: w = GATE_CYCLES / 1000;
    endcase
    if (w < 1) w = 1;
    return GW'(w - 1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-1:0], bus.fx_in};
  end

  assign fx_edge = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
  assign cnt_nxt = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(fx_edge);
  assign ovf_nxt = ovf_q | (cnt_nxt == CNT_MAX);

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    close   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          state_d = S_GATE;
          gate_d  = win_last(bus.gate_sel);
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_GATE: begin
        if (!bus.en) begin
          state_d = S_IDLE;
        end else if (gate_q == '0) begin
          // Final cycle's edge goes into the report; the next window starts clean.
          close  = 1'b1;
          gate_d = win_last(bus.gate_sel);
          cnt_d  = '0;
          ovf_d  = 1'b0;
        end else begin
          gate_d = gate_q - GW'(1);
          cnt_d  = cnt_nxt;
          ovf_d  = ovf_nxt;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gate_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef FREQ_METER_BCD_EN
  localparam int CW = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam int BW = 4 * BCD_DIGITS;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] BCD_LIM = pow10(BCD_DIGITS);

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  typedef enum logic {C_IDLE, C_CONV} conv_t;

  conv_t            conv_q, conv_d;
  logic [CW-1:0]    ccnt_q, ccnt_d;
  logic [CNT_W-1:0] val_q, val_d, sh_q, sh_d;
  logic [BW-1:0]    bcd_q, bcd_d, bcd_adj, bcd_step, freq_bcd_q, freq_bcd_d;
  logic             cov_q, cov_d, big_q, big_d;
  logic [CNT_W-1:0] freq_d;
  logic             overflow_d, valid_d;

  assign bcd_adj  = add3(bcd_q);
  assign bcd_step = (bcd_adj << 1) | BW'(sh_q[CNT_W-1]);

  always_comb begin
    conv_d     = conv_q;
    ccnt_d     = ccnt_q;
    val_d      = val_q;
    sh_d       = sh_q;
    bcd_d      = bcd_q;
    cov_d      = cov_q;
    big_d      = big_q;
    freq_d     = freq_q;
    overflow_d = overflow_q;
    freq_bcd_d = freq_bcd_q;
    valid_d    = 1'b0;
    case (conv_q)
      C_IDLE: begin
        if (close) begin
          conv_d = C_CONV;
          ccnt_d = CW'(CNT_W - 1);
          val_d  = cnt_nxt;
          sh_d   = cnt_nxt;
          bcd_d  = '0;
          cov_d  = ovf_nxt;
          big_d  = (64'(cnt_nxt) >= BCD_LIM);
        end
      end
      C_CONV: begin
        sh_d   = sh_q << 1;
        bcd_d  = bcd_step;
        ccnt_d = ccnt_q - CW'(1);
        // A window closing mid-conversion is lost; the pending report flags it.
        if (close) cov_d = 1'b1;
        if (ccnt_q == '0) begin
          conv_d     = C_IDLE;
          valid_d    = 1'b1;
          freq_d     = val_q;
          overflow_d = cov_q | big_q | close;
          freq_bcd_d = big_q ? {BCD_DIGITS{4'h9}} : bcd_step;
        end
      end
      default: conv_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_q     <= C_IDLE;
      ccnt_q     <= '0;
      val_q      <= '0;
      sh_q       <= '0;
      bcd_q      <= '0;
      cov_q      <= 1'b0;
      big_q      <= 1'b0;
      freq_q     <= '0;
      overflow_q <= 1'b0;
      freq_bcd_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      conv_q     <= conv_d;
      ccnt_q     <= ccnt_d;
      val_q      <= val_d;
      sh_q       <= sh_d;
      bcd_q      <= bcd_d;
      cov_q      <= cov_d;
      big_q      <= big_d;
      freq_q     <= freq_d;
      overflow_q <= overflow_d;
      freq_bcd_q <= freq_bcd_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.freq_bcd = freq_bcd_q;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_q     <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= close;
      if (close) begin
        freq_q     <= cnt_nxt;
        overflow_q <= ovf_nxt;
      end
    end
  end
`endif

  assign bus.freq     = freq_q;
  assign bus.overflow = overflow_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = (state_q == S_GATE);
endmodule

// File: tb/tb_freq_meter_gated.sv
// Directed bench for freq_meter_gated: expected reports queued at stimulus time, checked on each valid.
module tb_freq_meter_gated;
  localparam int GATE_CYCLES = 1000;
  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int BCD_DIGITS  = 8;
`ifdef FREQ_METER_BCD_EN
  localparam int LAT = CNT_W + 1;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int   lo;
    int   hi;
    logic ovf;
    int   gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef FREQ_METER_BCD_EN
  freq_meter_gated_if #(.CNT_W(CNT_W), .BCD_DIGITS(BCD_DIGITS)) bus ();
`else
  freq_meter_gated_if #(.CNT_W(CNT_W)) bus ();
`endif

  freq_meter_gated #(
    .GATE_CYCLES(GATE_CYCLES),
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .BCD_DIGITS (BCD_DIGITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mark = 0;
  int nvalid = 0;
  int sum = 0;
  int per = 40;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4*BCD_DIGITS-1:0] to_bcd(input int v);
    logic [4*BCD_DIGITS-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Square-wave source on fx_in, period per clk cycles, driven on falling edges.
  initial begin
    bus.fx_in = 1'b0;
    forever begin
      bus.fx_in = 1'b1;
      repeat (per / 2) @(negedge clk);
      bus.fx_in = 1'b0;
      repeat (per - per / 2) @(negedge clk);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 64'(bus.valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("valid_gap", 64'(cyc - mark), 64'(e.gap));
          if (e.lo == e.hi) begin
            check("freq", 64'(bus.freq), 64'(e.lo));
            check("overflow", 64'(bus.overflow), 64'(e.ovf));
`ifdef FREQ_METER_BCD_EN
            check("freq_bcd", 64'(bus.freq_bcd), 64'(to_bcd(e.lo)));
`endif
          end else begin
            check("freq_range", 64'(bus.freq >= CNT_W'(e.lo) && bus.freq <= CNT_W'(e.hi)), 64'd1);
            sum += int'(bus.freq);
          end
        end
        mark = cyc;
        nvalid++;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_valids(input int n, input int budget);
    int target;
    int t;
    target = nvalid + n;
    t = 0;
    while (nvalid < target && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("valid_count", 64'(nvalid), 64'(target));
  endtask

  task automatic push(input int lo, input int hi, input logic ovf, input int gap);
    sb.push_back('{lo, hi, ovf, gap});
  endtask

  task automatic start();
    mark = cyc;
    bus.en = 1'b1;
  endtask

  task automatic stop();
    bus.en = 1'b0;
    wait_cycles(1);
    check("busy_after_stop", 64'(bus.busy), 64'd0);
  endtask

  task automatic setup(input int p, input logic [1:0] sel);
    per = p;
    bus.gate_sel = sel;
    wait_cycles(4 * p + 10);
  endtask

  // n back-to-back full-length windows with identical expected reports.
  task automatic burst(input int p, input int n, input int f, input logic o);
    setup(p, 2'd0);
    for (int i = 0; i < n; i++) push(f, f, o, (i == 0) ? GATE_CYCLES + LAT : GATE_CYCLES);
    start();
    wait_valids(n, n * GATE_CYCLES + LAT + 100);
    stop();
  endtask

  initial begin
    bus.en = 1'b0;
    bus.gate_sel = 2'd0;
    wait_cycles(3);
    check("rst_freq", 64'(bus.freq), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_valid", 64'(bus.valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
`ifdef FREQ_METER_BCD_EN
    check("rst_freq_bcd", 64'(bus.freq_bcd), 64'd0);
`endif
    rst = 1'b0;

    burst(40, 3, 25, 1'b0);
    burst(8, 1, 125, 1'b0);
    burst(4, 1, 250, 1'b0);
    // Synchronous drive makes a 2-cycle period reliable; 500 edges saturate the counter.
    burst(2, 1, 255, 1'b1);

    setup(20, 2'd1);
    push(5, 5, 1'b0, GATE_CYCLES / 10 + LAT);
    push(50, 50, 1'b0, GATE_CYCLES);
    start();
    wait_cycles(50);
    bus.gate_sel = 2'd0;
    wait_valids(2, GATE_CYCLES + GATE_CYCLES / 10 + LAT + 100);
    stop();

    setup(40, 2'd0);
    start();
    wait_cycles(500);
    check("busy_mid_window", 64'(bus.busy), 64'd1);
    stop();
    wait_cycles(GATE_CYCLES + 200);
    check("freq_hold_after_abort", 64'(bus.freq), 64'd50);
    check("ovf_hold_after_abort", 64'(bus.overflow), 64'd0);
    push(25, 25, 1'b0, GATE_CYCLES + LAT);
    start();
    wait_valids(1, GATE_CYCLES + LAT + 100);
    stop();

    start();
    wait_cycles(300);
    rst = 1'b1;
    #1;
    check("midrst_freq", 64'(bus.freq), 64'd0);
    check("midrst_overflow", 64'(bus.overflow), 64'd0);
    check("midrst_valid", 64'(bus.valid), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
`ifdef FREQ_METER_BCD_EN
    check("midrst_freq_bcd", 64'(bus.freq_bcd), 64'd0);
`endif
    bus.en = 1'b0;
    wait_cycles(3);
    rst = 1'b0;

    // Period 7 against 100-cycle windows walks edges through every window slot, the last included.
    setup(7, 2'd1);
    for (int i = 0; i < 14; i++)
      push(14, 15, 1'b0, (i == 0) ? GATE_CYCLES / 10 + LAT : GATE_CYCLES / 10);
    sum = 0;
    start();
    wait_valids(14, 14 * (GATE_CYCLES / 10) + LAT + 100);
    stop();
    check("edge_sum_14_windows", 64'(sum), 64'd200);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
